// File: rtl/dmem_access_if.sv
// Data-memory bus between the MEM-stage access controller and the memory.
interface dmem_access_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/dmem_access.sv
// MEM-stage load/store controller: lane decode, one req/ack transaction per
// access, pipeline stall, load alignment/extension and misalignment reject.
module dmem_access #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [2:0]  mem_size,
   input  logic [31:0] mem_wdata,
   output logic        mem_stall,
   output logic [31:0] mem_rdata,
   output logic        mem_done,
   output logic        mem_misaligned,
   output logic        bus_err,
   dmem_access_if.master bus
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             we_q;
   logic [29:0]      addr_q;
   logic [3:0]       be_q;
   logic [31:0]      wdata_q;
   logic [2:0]       size_q;
   logic [1:0]       off_q;
   logic [31:0]      rdata_q;
   logic             err_q;
   logic             req;

   logic [3:0]       lanes;
   logic             issue;
   logic             ack_hit;
   logic             timeout;

   // Byte enables for an access; zero means misaligned or illegal size.
   function automatic logic [3:0] lane_decode(input logic [1:0] off, input logic [1:0] sz);
      logic [3:0] be;
      be = 4'b0000;
      case (sz)
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = (off == 2'b00) ? 4'b0011 : ((off == 2'b10) ? 4'b1100 : 4'b0000);
         2'b10:   be = (off == 2'b00) ? 4'b1111 : 4'b0000;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Replicate right-aligned store data across all lanes of its size.
   function automatic logic [31:0] store_replicate(input logic [31:0] w, input logic [1:0] sz);
      logic [31:0] r;
      case (sz)
         2'b00:   r = {4{w[7:0]}};
         2'b01:   r = {2{w[15:0]}};
         default: r = w;
      endcase
      return r;
   endfunction

   // Pick the addressed byte/half out of the read word and extend it.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                               input logic [2:0] sz);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'b00:   b = word[7:0];
         2'b01:   b = word[15:8];
         2'b10:   b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (sz[1:0])
         2'b00:   r = sz[2] ? {24'd0, b} : {{24{b[7]}}, b};
         2'b01:   r = sz[2] ? {16'd0, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   assign lanes   = lane_decode(mem_addr[1:0], mem_size[1:0]);
   assign issue   = (state == IDLE) && mem_valid && (lanes != 4'b0000);
   assign ack_hit = (state == BUSY) && bus.bus_ack;
   assign timeout = (state == BUSY) && !bus.bus_ack && (cnt == CNT_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (issue) state_nxt = BUSY;
         BUSY:    if (ack_hit || timeout) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes decoded from the current state (stall/misaligned also see inputs in IDLE).
   always_comb begin
      mem_stall      = 1'b0;
      mem_misaligned = 1'b0;
      mem_done       = 1'b0;
      req            = 1'b0;
      case (state)
         IDLE: begin
            mem_stall      = issue;
            mem_misaligned = mem_valid && (lanes == 4'b0000);
         end
         BUSY: begin
            mem_stall = 1'b1;
            req       = 1'b1;
         end
         DONE:    mem_done = 1'b1;
         default: ;
      endcase
   end

   // Access latch, timeout counter and completion results.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         off_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= timeout;
         if (issue) begin
            cnt     <= '0;
            we_q    <= mem_we;
            addr_q  <= mem_addr[31:2];
            be_q    <= lanes;
            wdata_q <= store_replicate(mem_wdata, mem_size[1:0]);
            size_q  <= mem_size;
            off_q   <= mem_addr[1:0];
         end else if (state == BUSY) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (ack_hit)
            rdata_q <= we_q ? 32'd0 : load_extend(bus.bus_rdata, off_q, size_q);
         else if (timeout)
            rdata_q <= 32'd0;
      end
   end

   assign mem_rdata     = rdata_q;
   assign bus_err       = err_q;
   assign bus.bus_req   = req;
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = {addr_q, 2'b00};
   assign bus.bus_be    = be_q;
   assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access.sv
// Directed bench for dmem_access with a scoreboard-driven completion monitor.
module tb_dmem_access;

   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_valid = 1'b0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [2:0]  mem_size = '0;
   logic [31:0] mem_wdata = '0;
   logic        mem_stall;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic        mem_misaligned;
   logic        bus_err;

   dmem_access_if bus_if();

   dmem_access #(.TIMEOUT(TIMEOUT)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_valid      (mem_valid),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_size       (mem_size),
      .mem_wdata      (mem_wdata),
      .mem_stall      (mem_stall),
      .mem_rdata      (mem_rdata),
      .mem_done       (mem_done),
      .mem_misaligned (mem_misaligned),
      .bus_err        (bus_err),
      .bus            (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          mis;
      logic [31:0] rdata;
      bit          err;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Completion monitor: every done/misaligned pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (mem_done || mem_misaligned)) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_response", 32'({mem_done, mem_misaligned}), 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk({e.name, "_misaligned"}, 32'(mem_misaligned), 32'(e.mis));
            chk({e.name, "_done"}, 32'(mem_done), 32'(!e.mis));
            if (!e.mis) begin
               chk({e.name, "_rdata"}, mem_rdata, e.rdata);
               chk({e.name, "_err"}, 32'(bus_err), 32'(e.err));
            end
         end
      end
      if (!rst && bus_err && !mem_done)
         chk("err_without_done", 32'(bus_err), 32'd0);
   end

   // Issue one access, answer the bus on BUSY cycle ack_cyc (0 = never), check bus side.
   task automatic access(input string name, input logic we, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata, input int ack_cyc,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                         input logic exp_err);
      exp_t e;
      int   busy;
      bit   seen_done;
      logic [31:0] exp_addr;
      exp_addr = {addr[31:2], 2'b00};
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_we = we; mem_addr = addr; mem_size = size; mem_wdata = wdata;
      e.mis = (exp_be == 4'b0000); e.rdata = exp_rdata; e.err = exp_err; e.name = name;
      sb_q.push_back(e);
      @(negedge clk);
      chk({name, "_issue_stall"}, 32'(mem_stall), 32'(exp_be != 4'b0000));
      chk({name, "_issue_req"}, 32'(bus_if.bus_req), 32'd0);
      if (exp_be == 4'b0000) begin
         @(posedge clk); #1;
         mem_valid = 1'b0;
         @(negedge clk);
         chk({name, "_no_req"}, 32'(bus_if.bus_req), 32'd0);
         return;
      end
      busy = 0;
      seen_done = 0;
      while (!seen_done && busy < 40) begin
         @(posedge clk); #1;
         bus_if.bus_ack   = (busy + 1 == ack_cyc);
         bus_if.bus_rdata = rdata;
         @(negedge clk);
         if (mem_done) begin
            seen_done = 1;
         end else begin
            busy++;
            chk({name, "_busy_req"}, 32'(bus_if.bus_req), 32'd1);
            chk({name, "_busy_stall"}, 32'(mem_stall), 32'd1);
            if (busy == 1) begin
               chk({name, "_bus_we"}, 32'(bus_if.bus_we), 32'(we));
               chk({name, "_bus_addr"}, bus_if.bus_addr, exp_addr);
               chk({name, "_bus_be"}, 32'(bus_if.bus_be), 32'(exp_be));
               if (we) chk({name, "_bus_wdata"}, bus_if.bus_wdata, exp_wdata);
            end
         end
      end
      if (!seen_done) begin
         chk({name, "_done_timeout"}, 32'(seen_done), 32'd1);
      end else begin
         chk({name, "_done_stall"}, 32'(mem_stall), 32'd0);
         chk({name, "_done_req"}, 32'(bus_if.bus_req), 32'd0);
         chk({name, "_busy_cycles"}, 32'(busy), (ack_cyc == 0) ? 32'(TIMEOUT) : 32'(ack_cyc));
      end
      @(posedge clk); #1;
      mem_valid = 1'b0;
      bus_if.bus_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_stall", 32'(mem_stall), 32'd0);
      chk("rst_done", 32'(mem_done), 32'd0);
      chk("rst_misaligned", 32'(mem_misaligned), 32'd0);
      chk("rst_err", 32'(bus_err), 32'd0);
      chk("rst_rdata", mem_rdata, 32'd0);
      chk("rst_req", 32'(bus_if.bus_req), 32'd0);
      chk("rst_we", 32'(bus_if.bus_we), 32'd0);
      chk("rst_addr", bus_if.bus_addr, 32'd0);
      chk("rst_be", 32'(bus_if.bus_be), 32'd0);
      chk("rst_wdata", bus_if.bus_wdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      //      name    we    addr           size    wdata          ack rdata          be       exp_wdata      exp_rdata      err
      access("lw",   1'b0, 32'h0000_0100, 3'b010, 32'h0,         2, 32'hDEAD_BEEF, 4'b1111, 32'h0,         32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      chk("rdata_hold", mem_rdata, 32'hDEAD_BEEF);
      access("lb",   1'b0, 32'h0000_0203, 3'b000, 32'h0,         1, 32'h8011_2233, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b0);
      access("lbu",  1'b0, 32'h0000_0203, 3'b100, 32'h0,         1, 32'h8011_2233, 4'b1000, 32'h0,         32'h0000_0080, 1'b0);
      access("sh",   1'b1, 32'h0000_0302, 3'b001, 32'h0000_ABCD, 1, 32'h1111_1111, 4'b1100, 32'hABCD_ABCD, 32'h0,         1'b0);
      access("lh_mis", 1'b0, 32'h0000_0101, 3'b001, 32'h0,       1, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b0);
      access("sw_mis", 1'b1, 32'h0000_0102, 3'b010, 32'h1234_5678, 1, 32'h0,       4'b0000, 32'h0,         32'h0,         1'b0);
      access("lw_to", 1'b0, 32'h0000_0400, 3'b010, 32'h0,         0, 32'hCAFE_F00D, 4'b1111, 32'h0,         32'h0,         1'b1);

      // Reset in the middle of BUSY; a late ack must be ignored.
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0500; mem_size = 3'b010;
      @(posedge clk); #1;
      mem_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_busy_req", 32'(bus_if.bus_req), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      bus_if.bus_ack = 1'b1;
      bus_if.bus_rdata = 32'h5555_AAAA;
      @(negedge clk);
      chk("rst_mid_req", 32'(bus_if.bus_req), 32'd0);
      chk("rst_mid_stall", 32'(mem_stall), 32'd0);
      chk("rst_mid_done", 32'(mem_done), 32'd0);
      @(posedge clk); #1;
      bus_if.bus_ack = 1'b0;
      @(negedge clk);
      chk("rst_mid_done2", 32'(mem_done), 32'd0);

      access("lhu",  1'b0, 32'h0000_0202, 3'b101, 32'h0,         2, 32'h8001_1234, 4'b1100, 32'h0,         32'h0000_8001, 1'b0);
      access("lh",   1'b0, 32'h0000_0202, 3'b001, 32'h0,         1, 32'h8001_1234, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b0);
      access("sb",   1'b1, 32'h0000_0001, 3'b000, 32'h1234_565A, 3, 32'h0,         4'b0010, 32'h5A5A_5A5A, 32'h0,         1'b0);
      access("ill",  1'b0, 32'h0000_0000, 3'b011, 32'h0,         1, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
